// File: rtl/pixel_sink.sv
// pixel_sink: takes pixel plot requests from a drawing engine, discards
// off-screen pixels (and counts them), buffers on-screen pixels in a
// 4-entry FIFO and writes them to a 320x240 framebuffer one at a time.
// Each write is issued as a single-cycle strobe and is then held until
// the framebuffer acknowledges it.
//
// Handshakes:
//   request side: a request is taken on a rising edge where plot=1 and
//     ready=1. ready depends only on registered FIFO occupancy, never on
//     plot, so the engine may hold plot high across ready=0 cycles.
//   memory side: mem_we is high for exactly one cycle per write, with
//     mem_addr/mem_data valid. The block then waits for mem_ack=1. mem_ack
//     is ignored while no write is outstanding.
module pixel_sink (
    input  logic        clk,
    input  logic        reset,
    input  logic        plot,
    input  logic [8:0]  X,
    input  logic [7:0]  Y,
    input  logic [5:0]  col,
    output logic        ready,
    output logic [16:0] mem_addr,
    output logic [5:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic [7:0]  drop_count,
    output logic        idle,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    localparam int DEPTH = 4;

    // FIFO entry layout: {address[16:0], colour[5:0]}
    logic [22:0] fifo_q [DEPTH];
    logic [22:0] fifo_d [DEPTH];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    state_t      state_q, state_d;
    logic [16:0] addr_q, addr_d;
    logic [5:0]  data_q, data_d;
    logic [7:0]  drop_q, drop_d;

    logic        in_range;
    logic        accept;
    logic        push;
    logic        drop;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic [16:0] pix_addr;
    logic [22:0] head;

    // Request decode: Y*320+X built from shifts so no multiplier is needed.
    always_comb begin
        in_range   = (X < 9'd320) && (Y < 8'd240);
        fifo_empty = (count_q == 3'd0);
        fifo_full  = (count_q == 3'd4);
        accept     = plot && !fifo_full;
        push       = accept && in_range;
        drop       = accept && !in_range;
        pix_addr   = ({9'd0, Y} << 8) + ({9'd0, Y} << 6) + {8'd0, X};
        head       = fifo_q[rd_ptr_q];
    end

    // Write FSM: pop the FIFO head into the output registers, strobe it
    // once, then wait for the acknowledge before taking the next entry.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (mem_ack) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (pop) begin
            addr_d = head[22:6];
            data_d = head[5:0];
        end
    end

    // FIFO storage, pointers, occupancy and saturating drop counter.
    // A pop on a full FIFO only frees the slot for the following cycle
    // because ready is derived from the registered count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fifo_d[i] = fifo_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {pix_addr, col};
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // State registers; reset drops everything buffered or in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            drop_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            drop_q   <= drop_d;
        end
    end

    // Outputs come straight from registered state.
    always_comb begin
        ready      = !fifo_full;
        mem_we     = (state_q == S_ISSUE);
        mem_addr   = addr_q;
        mem_data   = data_q;
        drop_count = drop_q;
        idle       = (state_q == S_IDLE) && fifo_empty;
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_pixel_sink.sv
// Bench for pixel_sink: directed pixel requests, expected framebuffer
// writes queued at issue time and checked by an independent monitor.
module tb_pixel_sink;

    logic        clk;
    logic        reset;
    logic        plot;
    logic [8:0]  X;
    logic [7:0]  Y;
    logic [5:0]  col;
    logic        ready;
    logic [16:0] mem_addr;
    logic [5:0]  mem_data;
    logic        mem_we;
    logic        mem_ack;
    logic [7:0]  drop_count;
    logic        idle;
    logic [1:0]  state_dbg;

    logic [22:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        auto_ack = 1'b0;

    pixel_sink dut (
        .clk        (clk),
        .reset      (reset),
        .plot       (plot),
        .X          (X),
        .Y          (Y),
        .col        (col),
        .ready      (ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .drop_count (drop_count),
        .idle       (idle),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [22:0] exp_word(input int x, input int y, input int c);
        logic [16:0] a;
        logic [5:0]  d;
        a = 17'(y * 320 + x);
        d = 6'(c);
        return {a, d};
    endfunction

    // driver: present one request at the next falling edge; plot stays high
    task automatic send(input int x, input int y, input int c);
        @(negedge clk);
        plot = 1'b1;
        X    = 9'(x);
        Y    = 8'(y);
        col  = 6'(c);
        check("send_ready", 32'(ready), 32'd1);
        if (x < 320 && y < 240) exp_q.push_back(exp_word(x, y, c));
    endtask

    task automatic release_plot();
        @(negedge clk);
        plot = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (idle && exp_q.size() == 0) done = 1'b1;
        end
        check("drain_idle", 32'(done), 32'd1);
    endtask

    // ack responder: raises mem_ack while a write is being issued and for
    // the following cycle, so the ack is also seen (and must be ignored)
    // during the strobe cycle itself
    initial begin
        logic prev_we;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (auto_ack) mem_ack = mem_we || prev_we;
            prev_we = mem_we;
        end
    end

    // scoreboard monitor: every write strobe must match the queue head
    initial begin
        logic [22:0] e;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(mem_addr), 32'h1FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(mem_addr), 32'(e[22:6]));
                    check("write_data", 32'(mem_data), 32'(e[5:0]));
                end
            end
        end
    end

    // stimulus
    initial begin
        reset   = 1'b0;
        plot    = 1'b0;
        X       = '0;
        Y       = '0;
        col     = '0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // single write with exact latency
        send(160, 120, 6'h3F);
        release_plot();
        check("lat_c1_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("lat_c2_we", 32'(mem_we), 32'd1);
        check("lat_c2_addr", 32'(mem_addr), 32'd38560);
        check("lat_c2_data", 32'(mem_data), 32'h3F);
        @(negedge clk);
        check("lat_c3_we", 32'(mem_we), 32'd0);
        check("lat_c3_idle", 32'(idle), 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("lat_c4_idle", 32'(idle), 32'd1);
        check("single_addr_hold", 32'(mem_addr), 32'd38560);

        // corner pixels
        auto_ack = 1'b1;
        send(319, 239, 6'h30);
        send(0, 0, 6'h0C);
        send(1, 1, 6'h03);
        release_plot();
        wait_idle();
        check("corner_addr_hold", 32'(mem_addr), 32'd321);

        // out of range
        send(320, 0, 6'h11);
        send(0, 240, 6'h22);
        release_plot();
        repeat (4) @(negedge clk);
        check("drop_two", 32'(drop_count), 32'd2);
        check("drop_idle", 32'(idle), 32'd1);
        for (int i = 0; i < 300; i++) send(320 + (i % 192), i % 256, i % 64);
        release_plot();
        @(negedge clk);
        check("drop_saturate", 32'(drop_count), 32'd255);

        // backpressure: no acks, plot held for 8 cycles
        auto_ack = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            plot = 1'b1;
            X    = 9'(k * 10 + 1);
            Y    = 8'(k + 3);
            col  = 6'(k + 1);
            check("bp_ready", 32'(ready), (k < 5) ? 32'd1 : 32'd0);
            if (k < 5) exp_q.push_back(exp_word(k * 10 + 1, k + 3, k + 1));
        end
        @(negedge clk);
        plot = 1'b0;
        check("bp_full_hold", 32'(ready), 32'd0);
        check("bp_state_wait", 32'(state_dbg), 32'd2);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("bp_ready_after_pop", 32'(ready), 32'd1);
        auto_ack = 1'b1;
        wait_idle();

        // reset mid-operation: 3 buffered, one write awaiting ack
        auto_ack = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        send(10, 20, 6'h01);
        send(11, 21, 6'h02);
        send(12, 22, 6'h03);
        send(13, 23, 6'h04);
        release_plot();
        check("mid_state_wait", 32'(state_dbg), 32'd2);
        check("mid_ready", 32'(ready), 32'd1);
        exp_q.delete();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_idle", 32'(idle), 32'd1);
        check("mid_rst_drop", 32'(drop_count), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", 32'(idle), 32'd1);
        auto_ack = 1'b1;
        send(5, 7, 6'h15);
        release_plot();
        wait_idle();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
